dev_alu_mc: RTL and testbench
=============================

DEV_ALU_MC -- requirements
Module: dev_alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand/result width in bits (legal: power of two, 16..64).
REQ-002 The block SHALL have parameter MUL_STEP, default 1, giving the multiplier bits retired per iteration cycle (legal: 1, 2, 4).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port op_valid, input, 1, meaning a request is presented.
REQ-006 The block SHALL have port op_ready, output, 1, meaning a request can be accepted this cycle.
REQ-007 The block SHALL have port op, input, pkg_alu::op_t, the operation code.
REQ-008 The block SHALL have ports a and b, input, WIDTH, the operands; result is b OP a.
REQ-009 The block SHALL have port res_valid, output, 1, a one-cycle pulse marking a new result.
REQ-010 The block SHALL have port s, output, WIDTH, the held result.
REQ-011 The block SHALL have ports cf, of, zf, sf, output, 1 each, the held carry, overflow, zero and sign flags.

Function
REQ-012 A request SHALL be accepted on a cycle where op_valid and op_ready are both 1; a, b and op are captured then and may change afterwards.
REQ-013 States SHALL be IDLE, RUN and DONE; op_ready SHALL be 1 in IDLE and DONE and 0 in RUN.
REQ-014 ADD, SUB, AND, SHR and SHL SHALL go IDLE/DONE -> DONE on acceptance, with s valid and res_valid=1 in the following cycle (latency 1).
REQ-015 ADD/SUB SHALL compute b+a and b-a, with cf = carry/borrow out and of = signed overflow; all other ops SHALL clear cf and of.
REQ-016 SHR/SHL SHALL shift b logically by a[$clog2(WIDTH)-1:0].
REQ-017 MULW SHALL be an unsigned WIDTH x WIDTH multiply returning the low WIDTH bits via shift-add, taking WIDTH/MUL_STEP cycles in RUN before DONE; cf SHALL be 1 iff the upper product half is nonzero.
REQ-018 DIV and MOD SHALL be unsigned restoring division (quotient and remainder of b/a respectively), taking WIDTH cycles in RUN.
REQ-019 If a=0, DIV SHALL return all-ones, MOD SHALL return b, and cf=1, in the same cycle count as a normal division.
REQ-020 NOP SHALL be accepted without a state change or res_valid pulse; s and the flags SHALL keep their held values.
REQ-021 An unknown op SHALL complete as latency 1 with s=0, cf=0 and of=0.
REQ-022 res_valid SHALL be 1 for exactly one cycle on entry to DONE; DONE SHALL fall back to IDLE after that cycle unless a new request is accepted there (back-to-back allowed).
REQ-023 s, cf and of SHALL change only on a completion; zf=(s==0) and sf=s[WIDTH-1] SHALL follow s combinationally.
REQ-024 op_valid during RUN SHALL be ignored and SHALL not disturb the operation in progress.

Reset
REQ-025 While rst_n=0 at a clk edge, the block SHALL enter IDLE, abort any RUN operation with no res_valid, and clear s, cf, of, res_valid and the iteration counter.
REQ-026 After reset, op_ready=1, zf=1 and sf=0.

Configuration
REQ-027 With macro DEV_ALU_MC_DIV_EN defined, the divider and the DIV/MOD ops SHALL be present.
REQ-028 Without DEV_ALU_MC_DIV_EN, DIV/MOD SHALL be treated as unknown ops (REQ-021) and no divider logic SHALL be synthesised.

Structure
REQ-029 pkg_alu SHALL hold op_t, including the new MULW, DIV and MOD encodings, and the state enum alu_mc_state_t.
REQ-030 The iterative datapath SHALL be the sub-module alu_mc_iter (shift-add/restoring core with start/done); the single-cycle ops stay in dev_alu_mc.

Verification
REQ-031 Bench SHALL cover: ADD with b=0x7FFF_FFFF_FFFF_FFFF, a=1 -> next cycle s=0x8000_0000_0000_0000, of=1, cf=0, sf=1, res_valid pulse.
REQ-032 Bench SHALL cover: MULW with b=0xFFFF_FFFF_FFFF_FFFF, a=2, MUL_STEP=1 -> op_ready low 64 cycles, then s=0xFFFF_FFFF_FFFF_FFFE, cf=1.
REQ-033 Bench SHALL cover: DIV with b=100, a=7 -> s=14; MOD with the same operands -> s=2; DIV with b=5, a=0 -> s=all-ones, cf=1.
REQ-034 Bench SHALL cover: rst_n low at cycle 10 of a DIV -> no res_valid, s=0, zf=1, and a following SUB with b=3, a=5 -> s=0xFFFF_FFFF_FFFF_FFFE, cf=1.
REQ-035 Bench SHALL cover: NOP after SUB, then op_valid held during RUN of MULW -> s unchanged, and the extra request is not accepted.
REQ-036 Bench SHALL cover: back-to-back ADD accepted in DONE -> res_valid on consecutive cycles, with correct results both times.

Source files
------------

// File: rtl/dev_alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, FSM states and
// iterative-core modes. The divider ops exist in the encoding regardless of
// DEV_ALU_MC_DIV_EN; the macro only decides whether the datapath honours them.
package pkg_alu;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHL  = 4'd5,
        OP_MULW = 4'd6,
        OP_DIV  = 4'd7,
        OP_MOD  = 4'd8
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_mc_state_t;

    typedef enum logic [1:0] {
        ITER_MUL = 2'd0,
        ITER_DIV = 2'd1,
        ITER_MOD = 2'd2
    } iter_mode_t;

endpackage

// File: rtl/dev_alu_mc_iter.sv
// Iterative core: shift-add multiplier (MUL_STEP bits per cycle) and, when
// DEV_ALU_MC_DIV_EN is defined, a restoring divider (one bit per cycle).
// o_last flags the cycle whose step is final; o_result/o_cf then carry the
// completed value combinationally so the caller can register it that edge.
module alu_mc_iter
    import pkg_alu::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  iter_mode_t       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cf
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(WIDTH / MUL_STEP);
    localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(WIDTH);

    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;
    iter_mode_t         r_mode;

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_mcand_nxt;
    logic [WIDTH-1:0]   w_mplier_nxt;

    // Multiplier step: add the shifted multiplicand for each retired multiplier bit
    always_comb begin
        w_acc_nxt = r_acc;
        for (int k = 0; k < MUL_STEP; k++) begin
            if (r_mplier[k]) begin
                w_acc_nxt = w_acc_nxt + (r_mcand << k);
            end
        end
        w_mcand_nxt  = r_mcand << MUL_STEP;
        w_mplier_nxt = r_mplier >> MUL_STEP;
    end

`ifdef DEV_ALU_MC_DIV_EN
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_dz;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Divider step: a zero divisor always "subtracts", giving all-ones and rem=b
    always_comb begin
        w_rem_sh = {r_rem, r_quo[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, r_dvs};
        if (r_dz || !w_diff[WIDTH]) begin
            w_rem_nxt = r_dz ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
        end else begin
            w_rem_nxt = w_rem_sh[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
        end
    end

    // Divider operand registers: load on start, step while busy
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_rem <= '0;
            r_quo <= i_b;
            r_dvs <= i_a;
            r_dz  <= (i_a == '0);
        end else if (r_busy) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end
`endif

    // Iteration control: counter loaded on start, counts down while busy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_mode <= ITER_MUL;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= (i_mode == ITER_MUL) ? MUL_CYC : DIV_CYC;
            r_mode <= i_mode;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Multiplier operand registers: load on start, step while busy
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_b};
            r_mplier <= i_a;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
        end
    end

    assign o_last = r_busy && (r_cnt == CNT_W'(1));

    // Result select for the final step of the active operation
    always_comb begin
        o_result = w_acc_nxt[WIDTH-1:0];
        o_cf     = |w_acc_nxt[2*WIDTH-1:WIDTH];
        case (r_mode)
`ifdef DEV_ALU_MC_DIV_EN
            ITER_DIV: begin
                o_result = w_quo_nxt;
                o_cf     = r_dz;
            end
            ITER_MOD: begin
                o_result = w_rem_nxt;
                o_cf     = r_dz;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/dev_alu_mc.sv
// Multi-cycle ALU top: single-cycle ADD/SUB/AND/SHR/SHL, iterative MULW and,
// with DEV_ALU_MC_DIV_EN defined, DIV/MOD. Result is b OP a, held in s with
// flags until the next completion. Without the macro DIV/MOD act as unknown ops.
module dev_alu_mc
    import pkg_alu::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    output logic [WIDTH-1:0] s,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             sf
);

    localparam int SH_W = $clog2(WIDTH);

    alu_mc_state_t    r_state;
    logic [WIDTH-1:0] r_s;
    logic             r_cf;
    logic             r_of;
    logic             r_res_valid;

    logic             w_accept;
    logic             w_is_iter;
    iter_mode_t       w_iter_mode;
    logic             w_start;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_s1;
    logic             w_cf1;
    logic             w_of1;
    logic             w_iter_last;
    logic [WIDTH-1:0] w_iter_res;
    logic             w_iter_cf;

    assign w_accept = op_valid && (r_state != ST_RUN);
    assign w_start  = w_accept && w_is_iter;
    assign w_add    = {1'b0, b} + {1'b0, a};
    assign w_sub    = {1'b0, b} - {1'b0, a};

    // Decode which ops go to the iterative core
    always_comb begin
        w_is_iter   = 1'b0;
        w_iter_mode = ITER_MUL;
        case (op)
            OP_MULW: w_is_iter = 1'b1;
`ifdef DEV_ALU_MC_DIV_EN
            OP_DIV: begin
                w_is_iter   = 1'b1;
                w_iter_mode = ITER_DIV;
            end
            OP_MOD: begin
                w_is_iter   = 1'b1;
                w_iter_mode = ITER_MOD;
            end
`endif
            default: ;
        endcase
    end

    // Single-cycle result and flags; unknown ops yield zero with flags clear
    always_comb begin
        w_s1  = '0;
        w_cf1 = 1'b0;
        w_of1 = 1'b0;
        case (op)
            OP_ADD: begin
                w_s1  = w_add[WIDTH-1:0];
                w_cf1 = w_add[WIDTH];
                w_of1 = (b[WIDTH-1] == a[WIDTH-1]) && (w_add[WIDTH-1] != b[WIDTH-1]);
            end
            OP_SUB: begin
                w_s1  = w_sub[WIDTH-1:0];
                w_cf1 = w_sub[WIDTH];
                w_of1 = (b[WIDTH-1] != a[WIDTH-1]) && (w_sub[WIDTH-1] != b[WIDTH-1]);
            end
            OP_AND:  w_s1 = b & a;
            OP_SHR:  w_s1 = b >> a[SH_W-1:0];
            OP_SHL:  w_s1 = b << a[SH_W-1:0];
            default: ;
        endcase
    end

    alu_mc_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_mode   (w_iter_mode),
        .i_a      (a),
        .i_b      (b),
        .o_last   (w_iter_last),
        .o_result (w_iter_res),
        .o_cf     (w_iter_cf)
    );

    // Control FSM with registered result, flags and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_cf        <= 1'b0;
            r_of        <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_iter_last) begin
                        r_s         <= w_iter_res;
                        r_cf        <= w_iter_cf;
                        r_of        <= 1'b0;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    if (w_accept && (op != OP_NOP)) begin
                        if (w_is_iter) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_s         <= w_s1;
                            r_cf        <= w_cf1;
                            r_of        <= w_of1;
                            r_res_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign op_ready  = (r_state != ST_RUN);
    assign res_valid = r_res_valid;
    assign s         = r_s;
    assign cf        = r_cf;
    assign of        = r_of;
    assign zf        = (r_s == '0);
    assign sf        = r_s[WIDTH-1];

endmodule

// File: tb/tb_dev_alu_mc.sv
// Directed bench for dev_alu_mc (WIDTH=64, MUL_STEP=1). DIV/MOD expectations
// follow DEV_ALU_MC_DIV_EN: divider results when defined, unknown-op otherwise.
module tb_dev_alu_mc;
    import pkg_alu::*;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    op_t          op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic [W-1:0] s;
    logic         cf, of, zf, sf;

    int n_checks = 0;
    int n_fail   = 0;

    dev_alu_mc #(.WIDTH(W), .MUL_STEP(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .res_valid (res_valid),
        .s         (s),
        .cf        (cf),
        .of        (of),
        .zf        (zf),
        .sf        (sf)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         cf;
        logic         of;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one request, scramble operands after acceptance, wait for res_valid
    task automatic run_op(input op_t o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int lowc);
        op = o; a = av; b = bv; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; a = ~av; b = '0; op = OP_NOP;
        lat = 0; lowc = 0;
        while (res_valid !== 1'b1 && lat < 300) begin
            if (op_ready !== 1'b1) lowc++;
            lat++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int lat, lowc, pulses, i;
        logic [3:0] raw;
        raw = 4'hF;

        vecs[0] = '{OP_ADD, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[1] = '{OP_ADD, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{OP_SUB, 64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0};
        vecs[3] = '{OP_SUB, 64'd1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{OP_AND, 64'hFF00_FF00_FF00_FF00, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF000_F000_F000_F000, 1'b0, 1'b0};
        vecs[5] = '{OP_SHR, 64'h0100_0000_0000_003F, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b0};
        vecs[6] = '{OP_SHL, 64'd4, 64'd1, 64'd16, 1'b0, 1'b0};
        vecs[7] = '{OP_SHL, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[8] = '{op_t'(raw), 64'd1, 64'd2, 64'h0, 1'b0, 1'b0};

        rst_n = 1'b0; op_valid = 1'b0; op = OP_NOP; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", W'(op_ready), 64'd1);
        chk("rst_rv", W'(res_valid), 64'd0);
        chk("rst_s", s, 64'd0);
        chk("rst_zf", W'(zf), 64'd1);
        chk("rst_sf", W'(sf), 64'd0);
        chk("rst_cf_of", W'({cf, of}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-cycle table
        for (int k = 0; k < 9; k++) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, lat, lowc);
            chk($sformatf("v%0d_lat", k), W'(lat), 64'd0);
            chk($sformatf("v%0d_rv", k), W'(res_valid), 64'd1);
            chk($sformatf("v%0d_s", k), s, vecs[k].s);
            chk($sformatf("v%0d_cf", k), W'(cf), W'(vecs[k].cf));
            chk($sformatf("v%0d_of", k), W'(of), W'(vecs[k].of));
            chk($sformatf("v%0d_zf", k), W'(zf), W'(vecs[k].s == 64'd0));
            chk($sformatf("v%0d_sf", k), W'(sf), W'(vecs[k].s[W-1]));
            @(posedge clk); #1;
            chk($sformatf("v%0d_rv_drop", k), W'(res_valid), 64'd0);
        end

        // MULW all-ones * 2
        run_op(OP_MULW, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, lat, lowc);
        chk("mul_lat", W'(lat), 64'd64);
        chk("mul_ready_low", W'(lowc), 64'd64);
        chk("mul_rv", W'(res_valid), 64'd1);
        chk("mul_s", s, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mul_cf", W'(cf), 64'd1);
        chk("mul_of", W'(of), 64'd0);
        @(posedge clk); #1;
        chk("mul_rv_drop", W'(res_valid), 64'd0);
        chk("mul_ready_after", W'(op_ready), 64'd1);

        run_op(OP_MULW, 64'hFFFF_FFFF, 64'hFFFF_FFFF, lat, lowc);
        chk("mul32_s", s, 64'hFFFF_FFFE_0000_0001);
        chk("mul32_cf", W'(cf), 64'd0);

        // Division
`ifdef DEV_ALU_MC_DIV_EN
        run_op(OP_DIV, 64'd7, 64'd100, lat, lowc);
        chk("div_lat", W'(lat), 64'd64);
        chk("div_s", s, 64'd14);
        chk("div_cf", W'(cf), 64'd0);
        run_op(OP_MOD, 64'd7, 64'd100, lat, lowc);
        chk("mod_s", s, 64'd2);
        run_op(OP_DIV, 64'd0, 64'd5, lat, lowc);
        chk("div0_lat", W'(lat), 64'd64);
        chk("div0_s", s, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("div0_cf", W'(cf), 64'd1);
        run_op(OP_MOD, 64'd0, 64'd5, lat, lowc);
        chk("mod0_s", s, 64'd5);
        chk("mod0_cf", W'(cf), 64'd1);
`else
        run_op(OP_DIV, 64'd7, 64'd100, lat, lowc);
        chk("div_off_lat", W'(lat), 64'd0);
        chk("div_off_rv", W'(res_valid), 64'd1);
        chk("div_off_s", s, 64'd0);
        chk("div_off_cf", W'(cf), 64'd0);
`endif

        // SUB, then NOP keeps everything
        run_op(OP_SUB, 64'd5, 64'd3, lat, lowc);
        chk("sub_s", s, 64'hFFFF_FFFF_FFFF_FFFE);
        op = OP_NOP; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("nop_rv", W'(res_valid), 64'd0);
        chk("nop_s", s, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("nop_cf", W'(cf), 64'd1);
        chk("nop_ready", W'(op_ready), 64'd1);

        // MULW with op_valid held during RUN (ADD presented, must be ignored)
        op = OP_MULW; a = 64'd5; b = 64'd3; op_valid = 1'b1;
        @(posedge clk); #1;
        op = OP_ADD; a = 64'd1; b = 64'd1;
        i = 0; pulses = 0;
        while (res_valid !== 1'b1 && i < 300) begin
            if (i == 5) begin
                chk("hold_s_mid", s, 64'hFFFF_FFFF_FFFF_FFFE);
                chk("hold_ready_mid", W'(op_ready), 64'd0);
            end
            if (i >= 10) op_valid = 1'b0;
            i++;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        chk("hold_lat", W'(i), 64'd64);
        chk("hold_s", s, 64'd15);
        chk("hold_cf", W'(cf), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) pulses++;
        end
        chk("hold_extra_pulses", W'(pulses), 64'd0);
        chk("hold_s_after", s, 64'd15);

        // Back-to-back ADD accepted in DONE
        op = OP_ADD; a = 64'd5; b = 64'd10; op_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_rv1", W'(res_valid), 64'd1);
        chk("b2b_s1", s, 64'd15);
        a = 64'd22; b = 64'd20;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("b2b_rv2", W'(res_valid), 64'd1);
        chk("b2b_s2", s, 64'd42);
        @(posedge clk); #1;
        chk("b2b_rv_drop", W'(res_valid), 64'd0);
        chk("b2b_s_hold", s, 64'd42);

        // Reset ten cycles into an iterative op
`ifdef DEV_ALU_MC_DIV_EN
        op = OP_DIV;
`else
        op = OP_MULW;
`endif
        a = 64'd7; b = 64'd100; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("abort_ready_pre", W'(op_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_rv", W'(res_valid), 64'd0);
        chk("abort_s", s, 64'd0);
        chk("abort_zf", W'(zf), 64'd1);
        chk("abort_ready", W'(op_ready), 64'd1);
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (res_valid === 1'b1) pulses++;
        end
        chk("abort_no_pulse", W'(pulses), 64'd0);
        run_op(OP_SUB, 64'd5, 64'd3, lat, lowc);
        chk("abort_sub_lat", W'(lat), 64'd0);
        chk("abort_sub_s", s, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("abort_sub_cf", W'(cf), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
